fp_acc: RTL and testbench



---
 rtl/fp_acc_pkg.sv | 52 +++++
 rtl/fp_add.sv | 118 +++++++++++
 rtl/fp_acc.sv | 94 +++++++++
 tb/tb_fp_acc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_acc_pkg.sv
// Shared definitions for the FP accumulator slice.
// Provides the floating-point format enumeration with its exponent/mantissa
// widths, the accumulator FSM state type, and the canonical quiet NaN
// pattern for a given format.
package fp_acc_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP64:       return 11;
            FP16, FP8:  return 5;
            default:    return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(input fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    // Sign 0, exponent all ones, only the mantissa MSB set; right-aligned.
    function automatic logic [63:0] canonical_qnan(input fp_format_e fmt);
        int unsigned e;
        int unsigned m;
        e = exp_bits(fmt);
        m = man_bits(fmt);
        return (((64'd1 << e) - 64'd1) << m) | (64'd1 << (m - 1));
    endfunction

endpackage

// File: rtl/fp_add.sv
// Combinational IEEE-754 two-operand adder, round-to-nearest-even.
// Handles subnormals, overflow to infinity, and returns the canonical qNaN
// for any NaN operand or for inf + (-inf). Exact cancellation yields +0.
// Ports:
//   a_i, b_i : operands in format FpFormat
//   sum_o    : rounded sum
module fp_add
    import fp_acc_pkg::*;
#(
    parameter fp_format_e  FpFormat = FP32,
    parameter int unsigned WIDTH    = fp_width(FpFormat)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    localparam int unsigned E  = exp_bits(FpFormat);
    localparam int unsigned M  = man_bits(FpFormat);
    // carry + hidden + mantissa + guard/round/sticky
    localparam int unsigned WW = M + 5;
    localparam int unsigned XW = E + 2;
    localparam logic [WIDTH-1:0] QNAN = WIDTH'(canonical_qnan(FpFormat));

    // Subnormals share the exponent of the smallest normal.
    function automatic logic [XW-1:0] eff_exp(input logic [E-1:0] e);
        return (e == '0) ? XW'(1) : XW'(e);
    endfunction

    function automatic logic rne_up(input logic lsb, input logic guard, input logic rest);
        return guard & (rest | lsb);
    endfunction

    function automatic logic [XW-1:0] lzc(input logic [WW-2:0] v);
        logic [XW-1:0] cnt;
        cnt = XW'(WW - 1);
        for (int i = 0; i < WW - 1; i++) begin
            if (v[i]) cnt = XW'(WW - 2 - i);
        end
        return cnt;
    endfunction

    logic          sa, sb, sign_big, a_big, eff_sub;
    logic          nan_a, nan_b, inf_a, inf_b, overflow;
    logic [E-1:0]  ea, eb;
    logic [M-1:0]  ma, mb, man_f;
    logic [M:0]    sig_big, sig_small;
    logic [XW-1:0] exp_big, exp_small, shamt, lz, lshift, exp_n, exp_r;
    logic [2*WW-1:0] align;
    logic [WW-1:0] big_x, small_x, sum_x;
    logic [WW-2:0] norm_x;
    logic [M+1:0]  rounded;

    always_comb begin
        sa = a_i[WIDTH-1];
        ea = a_i[WIDTH-2:M];
        ma = a_i[M-1:0];
        sb = b_i[WIDTH-1];
        eb = b_i[WIDTH-2:M];
        mb = b_i[M-1:0];
        nan_a = (&ea) & (|ma);
        nan_b = (&eb) & (|mb);
        inf_a = (&ea) & ~(|ma);
        inf_b = (&eb) & ~(|mb);

        // Order operands by magnitude so the subtraction never goes negative.
        a_big     = {ea, ma} >= {eb, mb};
        eff_sub   = sa ^ sb;
        sign_big  = a_big ? sa : sb;
        sig_big   = a_big ? {|ea, ma} : {|eb, mb};
        sig_small = a_big ? {|eb, mb} : {|ea, ma};
        exp_big   = eff_exp(a_big ? ea : eb);
        exp_small = eff_exp(a_big ? eb : ea);

        // Alignment: bits shifted out of the window collapse into sticky.
        shamt = exp_big - exp_small;
        if (shamt > XW'(WW)) shamt = XW'(WW);
        big_x      = {1'b0, sig_big, 3'b000};
        align      = {1'b0, sig_small, 3'b000, {WW{1'b0}}} >> shamt;
        small_x    = align[2*WW-1:WW];
        small_x[0] = small_x[0] | (|align[WW-1:0]);
        sum_x      = eff_sub ? big_x - small_x : big_x + small_x;

        // Normalisation; left shifts stop at the minimum exponent so tiny
        // results land in the subnormal range instead of underflowing.
        lz     = '0;
        lshift = '0;
        if (sum_x[WW-1]) begin
            norm_x = {sum_x[WW-1:2], |sum_x[1:0]};
            exp_n  = exp_big + XW'(1);
        end else begin
            lz     = lzc(sum_x[WW-2:0]);
            lshift = (lz < exp_big - XW'(1)) ? lz : exp_big - XW'(1);
            norm_x = sum_x[WW-2:0] << lshift;
            exp_n  = exp_big - lshift;
        end

        rounded = {1'b0, norm_x[WW-2:3]}
                + (M+2)'(rne_up(norm_x[3], norm_x[2], norm_x[1] | norm_x[0]));
        if (rounded[M+1]) begin
            exp_r = exp_n + XW'(1);
            man_f = rounded[M:1];
        end else begin
            // No hidden bit after rounding means the result stayed subnormal.
            exp_r = rounded[M] ? exp_n : '0;
            man_f = rounded[M-1:0];
        end
        overflow = exp_r >= XW'((1 << E) - 1);

        sum_o = {sign_big, exp_r[E-1:0], man_f};
        if (overflow) sum_o = {sign_big, {E{1'b1}}, {M{1'b0}}};
        // Zero sum: cancellation gives +0, only (-0)+(-0) keeps the sign.
        if (sum_x == '0) sum_o = {(eff_sub ? 1'b0 : sa), {(WIDTH-1){1'b0}}};
        if (inf_a | inf_b) sum_o = {(inf_a ? sa : sb), {E{1'b1}}, {M{1'b0}}};
        if (nan_a | nan_b | (inf_a & inf_b & eff_sub)) sum_o = QNAN;
    end

endmodule

// File: rtl/fp_acc.sv
// Sequential FP accumulator fed by the fp_mul result stream.
// A job is started in IDLE with start_i and a length; that many products are
// summed (one per cycle, RNE) and the sum is offered on the output handshake.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i, cfg_len_i      : job start and product count (sampled in IDLE)
//   busy_o                  : job in progress (ACC or DONE)
//   in_valid_i/in_ready_o/in_data_i    : product stream
//   out_valid_o/out_ready_i/out_data_o : accumulated sum
module fp_acc
    import fp_acc_pkg::*;
#(
    parameter fp_format_e  FpFormat  = fp_format_e'(0),
    parameter int unsigned WIDTH     = fp_width(FpFormat),
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] cfg_len_i,
    output logic                 busy_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_data_o
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_sum;
    logic [CNT_WIDTH-1:0] cnt_q, len_q;

    fp_add #(
        .FpFormat (FpFormat)
    ) u_fp_add (
        .a_i   (acc_q),
        .b_i   (in_data_i),
        .sum_o (acc_sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (cfg_len_i != '0) len_q <= cfg_len_i;
                    end
                end
                ACC: begin
                    if (in_valid_i) begin
                        acc_q <= acc_sum;
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = (cfg_len_i != '0) ? ACC : DONE;
            end
            ACC: begin
                busy_o     = 1'b1;
                in_ready_o = 1'b1;
                if (in_valid_i && (cnt_q == len_q - CNT_WIDTH'(1))) state_d = DONE;
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                out_data_o  = acc_q;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_acc.sv
module tb_fp_acc;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] cfg_len_i;
    logic        busy_o;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    fp_acc dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .cfg_len_i   (cfg_len_i),
        .busy_o      (busy_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every sum the DUT hands over is checked against the queue.
    initial begin
        logic [31:0] exp_v;
        forever begin
            @(negedge clk);
            if (!rst_i && out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sum_unexpected: got %h, none pending", out_data_o);
                end else begin
                    exp_v = sb_q.pop_front();
                    check("sum", out_data_o, exp_v);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic begin_job(input int len, input logic [31:0] expv);
        start_i   = 1'b1;
        cfg_len_i = 16'(len);
        step();
        start_i   = 1'b0;
        cfg_len_i = '0;
        sb_q.push_back(expv);
    endtask

    task automatic feed(input logic [31:0] v, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid_i = 1'b0;
            check("busy_gap", 32'(busy_o), 32'd1);
            step();
        end
        in_valid_i = 1'b1;
        in_data_i  = v;
        check("in_ready_acc", 32'(in_ready_o), 32'd1);
        step();
        in_valid_i = 1'b0;
    endtask

    // Called right after the last handshake: the sum must already be valid.
    task automatic end_job();
        int k;
        check("valid_latency", 32'(out_valid_o), 32'd1);
        check("in_ready_done", 32'(in_ready_o), 32'd0);
        k = 0;
        while (!out_valid_o && k < 20) begin
            step();
            k++;
        end
        step();
        check("idle_after", 32'(busy_o), 32'd0);
    endtask

    task automatic run_job(input int n, input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3,
                           input logic [31:0] expv);
        logic [31:0] vals [4];
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        begin_job(n, expv);
        for (int i = 0; i < n; i++) feed(vals[i], 0);
        end_job();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; cfg_len_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
        repeat (3) step();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd0);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_data", out_data_o, 32'h0);
        rst_i = 1'b0;
        step();

        // 1 + 2 + 3 + 4 = 10
        run_job(4, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000);

        // Zero-length job with a product waiting that must not be taken.
        in_valid_i = 1'b1;
        in_data_i  = 32'h3F800000;
        begin_job(0, 32'h00000000);
        end_job();
        in_valid_i = 1'b0;

        // Gapped input, RNE tie 1 + 2^-24 -> 1.0, output stalled five cycles.
        out_ready_i = 1'b0;
        begin_job(2, 32'h3F800000);
        feed(32'h3F800000, 2);
        feed(32'h33800000, 2);
        in_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(out_valid_o), 32'd1);
            check("bp_data", out_data_o, 32'h3F800000);
            check("bp_busy", 32'(busy_o), 32'd1);
            check("bp_in_ready", 32'(in_ready_o), 32'd0);
            step();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        check("bp_data_release", out_data_o, 32'h3F800000);
        step();
        check("bp_idle_valid", 32'(out_valid_o), 32'd0);
        check("bp_idle_busy", 32'(busy_o), 32'd0);

        // Specials and boundaries.
        run_job(2, 32'h7F800000, 32'hFF800000, 0, 0, 32'h7FC00000);
        run_job(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 32'h7F800000);
        run_job(3, 32'h7F800001, 32'h3F800000, 32'hBF800000, 0, 32'h7FC00000);
        run_job(2, 32'hFF800000, 32'h3F800000, 0, 0, 32'hFF800000);
        run_job(2, 32'h3F800000, 32'hBF800000, 0, 0, 32'h00000000);
        run_job(2, 32'h80000000, 32'h80000000, 0, 0, 32'h00000000);
        run_job(2, 32'h00000001, 32'h00000001, 0, 0, 32'h00000002);
        run_job(2, 32'h00400000, 32'h00400000, 0, 0, 32'h00800000);

        // Reset after two of four handshakes; partial sum must vanish.
        start_i   = 1'b1;
        cfg_len_i = 16'd4;
        step();
        start_i   = 1'b0;
        feed(32'h3F800000, 0);
        feed(32'h40000000, 0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready_o), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_out_data", out_data_o, 32'h0);
        run_job(1, 32'h40000000, 0, 0, 0, 32'h40000000);

        // start_i during ACC with a different length is ignored.
        begin_job(4, 32'h41200000);
        feed(32'h3F800000, 0);
        start_i   = 1'b1;
        cfg_len_i = 16'd7;
        feed(32'h40000000, 0);
        start_i   = 1'b0;
        cfg_len_i = '0;
        feed(32'h40400000, 0);
        feed(32'h40800000, 0);
        end_job();

        // start_i coinciding with the output handshake is ignored.
        begin_job(1, 32'h40400000);
        feed(32'h40400000, 0);
        start_i   = 1'b1;
        cfg_len_i = 16'd2;
        end_job();
        start_i   = 1'b0;
        cfg_len_i = '0;
        check("start_at_done_valid", 32'(out_valid_o), 32'd0);

        repeat (3) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
